ram_rr_arbiter: RTL and testbench

RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

---
 rtl/ram_rr_arbiter.sv | 90 +++++++++
 tb/tb_ram_rr_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ requesters onto one RAM port.
// Read responses return one cycle after the grant, tagged by requester.
module ram_rr_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             arb_en,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             ram_en,
    output logic                             ram_we,
    output logic [ADDRESS_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]            ram_din,
    input  logic [DATA_WIDTH-1:0]            ram_dout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [IW-1:0] ptr_q, ptr_d;
    logic          pend_q, pend_d;
    logic [IW-1:0] pidx_q, pidx_d;

    logic          found;
    logic [IW-1:0] gidx;
    logic          active;
    int            j;

    // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                gidx  = IW'(j);
            end
        end
    end

    assign active = rst_n & arb_en & found;

    always_comb begin
        req_ready = '0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        ptr_d     = ptr_q;
        pend_d    = 1'b0;
        pidx_d    = pidx_q;
        if (active) begin
            req_ready = ONE << gidx;
            ram_en    = 1'b1;
            ram_we    = req_we[gidx];
            ram_addr  = req_addr[gidx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            ram_din   = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
            ptr_d     = (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
            pend_d    = ~req_we[gidx];
            pidx_d    = gidx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            pend_q <= 1'b0;
            pidx_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            pend_q <= pend_d;
            pidx_q <= pidx_d;
        end
    end

    assign rsp_valid = pend_q ? (ONE << pidx_q) : '0;
    assign rsp_rdata = pend_q ? ram_dout : '0;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed vector table plus random traffic
// checked against a round-robin reference model and a behavioural RAM.
module tb_ram_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arb_en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_en;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout = '0;

    ram_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    // Reference model state
    int            m_ptr = 0;
    bit            m_pend = 0;
    int            m_pidx = 0;
    logic [DW-1:0] m_pdata = '0;
    logic [DW-1:0] m_mem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    typedef struct {
        logic            rst;
        logic            en;
        logic [N-1:0]    valid;
        logic [N-1:0]    we;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] wdata;
        logic [N-1:0]    exp_ready;
        logic [N-1:0]    exp_rsp;
        logic [DW-1:0]   exp_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic en,
                       input logic [N-1:0] v, input logic [N-1:0] w,
                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                       input logic [N-1:0] er, input logic [N-1:0] es,
                       input logic [DW-1:0] ed);
        vec_t t;
        t.rst = rst; t.en = en; t.valid = v; t.we = w;
        t.addr = a; t.wdata = d;
        t.exp_ready = er; t.exp_rsp = es; t.exp_rdata = ed;
        vq.push_back(t);
    endtask

    // Drive one cycle (called just after a falling edge), check, advance.
    task automatic step(input logic rst, input logic en,
                        input logic [N-1:0] v, input logic [N-1:0] w,
                        input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        int g;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        rst_n = rst; arb_en = en; req_valid = v; req_we = w;
        req_addr = a; req_wdata = d;
        if (!rst) begin
            m_ptr = 0;
            m_pend = 0;
        end
        #1;
        g = -1;
        if (rst && en)
            for (int k = N - 1; k >= 0; k--)
                if (v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        ga = (g >= 0) ? a[g*AW +: AW] : '0;
        gd = (g >= 0) ? d[g*DW +: DW] : '0;
        chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 0);
        chk("ram_en", 32'(ram_en), 32'(g >= 0));
        chk("ram_we", 32'(ram_we), (g >= 0) ? 32'(w[g]) : 0);
        chk("ram_addr", 32'(ram_addr), 32'(ga));
        chk("ram_din", 32'(ram_din), 32'(gd));
        chk("rsp_valid", 32'(rsp_valid), m_pend ? 32'(1 << m_pidx) : 0);
        chk("rsp_rdata", 32'(rsp_rdata), m_pend ? 32'(m_pdata) : 0);
        @(posedge clk);
        m_pend = 0;
        if (g >= 0) begin
            if (w[g]) m_mem[ga] = gd;
            else begin
                m_pend = 1;
                m_pidx = g;
                m_pdata = m_mem[ga];
            end
            m_ptr = (g + 1) % N;
        end
        @(negedge clk);
    endtask

    localparam logic [N*AW-1:0] A5_1 = {3'd0, 3'd5, 3'd0};
    localparam logic [N*DW-1:0] D5_1 = {8'h00, 8'hA5, 8'h00};
    localparam logic [N*AW-1:0] A5_2 = {3'd5, 3'd0, 3'd0};
    localparam logic [N*AW-1:0] ABC  = {3'd3, 3'd2, 3'd1};
    localparam logic [N*DW-1:0] DBC  = {8'h33, 8'h22, 8'h11};

    initial begin
        add(0, 1, 3'b111, 3'b000, ABC, DBC, 3'b000, 3'b000, 8'h00);
        add(1, 1, 3'b010, 3'b010, A5_1, D5_1, 3'b010, 3'b000, 8'h00);
        add(1, 1, 3'b100, 3'b000, A5_2, '0, 3'b100, 3'b000, 8'h00);
        add(1, 1, 3'b000, 3'b000, '0, '0, 3'b000, 3'b100, 8'hA5);
        add(1, 1, 3'b111, 3'b111, ABC, DBC, 3'b001, 3'b000, 8'h00);
        add(1, 1, 3'b111, 3'b111, ABC, DBC, 3'b010, 3'b000, 8'h00);
        add(1, 1, 3'b111, 3'b111, ABC, DBC, 3'b100, 3'b000, 8'h00);
        add(1, 1, 3'b111, 3'b111, ABC, DBC, 3'b001, 3'b000, 8'h00);
        add(1, 1, 3'b111, 3'b111, ABC, DBC, 3'b010, 3'b000, 8'h00);
        add(1, 1, 3'b111, 3'b111, ABC, DBC, 3'b100, 3'b000, 8'h00);
        add(1, 1, 3'b001, 3'b111, ABC, DBC, 3'b001, 3'b000, 8'h00);
        add(1, 1, 3'b101, 3'b111, ABC, DBC, 3'b100, 3'b000, 8'h00);
        add(1, 1, 3'b101, 3'b111, ABC, DBC, 3'b001, 3'b000, 8'h00);
        add(1, 1, 3'b010, 3'b000, ABC, DBC, 3'b010, 3'b000, 8'h00);
        add(1, 0, 3'b111, 3'b000, ABC, DBC, 3'b000, 3'b010, 8'h22);
        add(1, 0, 3'b111, 3'b000, ABC, DBC, 3'b000, 3'b000, 8'h00);
        add(1, 1, 3'b001, 3'b000, ABC, DBC, 3'b001, 3'b000, 8'h00);
        add(0, 1, 3'b111, 3'b000, ABC, DBC, 3'b000, 3'b000, 8'h00);
        add(1, 1, 3'b000, 3'b000, ABC, DBC, 3'b000, 3'b000, 8'h00);
        add(1, 1, 3'b111, 3'b111, ABC, DBC, 3'b001, 3'b000, 8'h00);

        #1;
        chk("reset ready", 32'(req_ready), 0);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        foreach (vq[i]) begin
            rst_n = vq[i].rst; arb_en = vq[i].en;
            req_valid = vq[i].valid; req_we = vq[i].we;
            #1;
            chk($sformatf("vec%0d ready", i), 32'(req_ready),
                32'(vq[i].exp_ready));
            chk($sformatf("vec%0d rsp", i), 32'(rsp_valid),
                32'(vq[i].exp_rsp));
            chk($sformatf("vec%0d rdata", i), 32'(rsp_rdata),
                32'(vq[i].exp_rdata));
            step(vq[i].rst, vq[i].en, vq[i].valid, vq[i].we,
                 vq[i].addr, vq[i].wdata);
        end

        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                 N'($urandom), N'($urandom), (N*AW)'($urandom),
                 (N*DW)'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
